// File: rtl/qsys_st_conduit_arbiter.sv
// qsys_st_conduit_arbiter
//   Round-robin arbiter that shares one registered conduit (sigOut) among
//   NUM_REQ Avalon-ST sinks. Each accepted beat drives sigOut and sigSource,
//   and pulses sigStrobe for one cycle.
//   Optional macro QSYS_ARB_HOLD_EN: after each accept, sigOut is held for
//   HOLD_CYCLES cycles. During that time no grants are issued and busy is 1.
module qsys_st_conduit_arbiter #(
    parameter int WIDTH       = 8,
    parameter int NUM_REQ     = 4,
    parameter int HOLD_CYCLES = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ*WIDTH-1:0]   sinkData,
    input  logic [NUM_REQ-1:0]         sinkValid,
    output logic [NUM_REQ-1:0]         sinkReady,
    output logic [WIDTH-1:0]           sigOut,
    output logic                       sigStrobe,
    output logic [((NUM_REQ > 1) ? $clog2(NUM_REQ) : 1)-1:0] sigSource,
    output logic                       busy
);
    localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0][WIDTH-1:0] lanes;
    logic [SW-1:0]                 lastGrant;
    logic [SW-1:0]                 win;
    logic                          anyv;
    logic                          idle;
    logic                          accept;

    assign lanes = sinkData;

    // Round-robin scan starting one past the last winner, wrapping modulo NUM_REQ
    always_comb begin
        int idx;
        win  = '0;
        anyv = 1'b0;
        idx  = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(lastGrant) + k) % NUM_REQ;
            if (!anyv && sinkValid[idx]) begin
                anyv = 1'b1;
                win  = SW'(idx);
            end
        end
    end

    // The grant is gated by reset so that a beat offered during reset is never accepted
    assign accept = anyv & idle & ~reset;

    // One-hot ready for the winner only
    always_comb begin
        sinkReady = '0;
        if (accept) sinkReady[win] = 1'b1;
    end

`ifdef QSYS_ARB_HOLD_EN
    typedef enum logic {IDLE, HOLD} state_t;

    state_t     state, state_n;
    logic [7:0] holdCnt, holdCnt_n;

    // FSM state and hold counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            holdCnt <= '0;
        end else begin
            state   <= state_n;
            holdCnt <= holdCnt_n;
        end
    end

    // Next-state logic: enter HOLD on each accept, then count down to zero and return to IDLE
    always_comb begin
        state_n   = state;
        holdCnt_n = holdCnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n   = HOLD;
                    holdCnt_n = 8'(HOLD_CYCLES - 1);
                end
            end
            HOLD: begin
                if (holdCnt == 8'd0) state_n = IDLE;
                else                 holdCnt_n = holdCnt - 8'd1;
            end
            default: state_n = IDLE;
        endcase
    end

    assign idle = (state == IDLE);
    assign busy = (state == HOLD);
`else
    assign idle = 1'b1;
    assign busy = 1'b0;
`endif

    // Register the accepted beat onto the conduit and update the round-robin pointer
    always_ff @(posedge clock) begin
        if (reset) begin
            sigOut    <= '0;
            sigSource <= '0;
            sigStrobe <= 1'b0;
            lastGrant <= SW'(NUM_REQ - 1);
        end else begin
            sigStrobe <= accept;
            if (accept) begin
                sigOut    <= lanes[win];
                sigSource <= win;
                lastGrant <= win;
            end
        end
    end

endmodule

// File: tb/tb_qsys_st_conduit_arbiter.sv
// Bench for qsys_st_conduit_arbiter: directed scenarios followed by random
// traffic, checked against a priority-queue reference model.
module tb_qsys_st_conduit_arbiter;
    localparam int WIDTH       = 8;
    localparam int NUM_REQ     = 4;
    localparam int HOLD_CYCLES = 4;

    logic                     clock = 1'b0;
    logic                     reset;
    logic [NUM_REQ*WIDTH-1:0] sinkData;
    logic [NUM_REQ-1:0]       sinkValid;
    logic [NUM_REQ-1:0]       sinkReady;
    logic [WIDTH-1:0]         sigOut;
    logic                     sigStrobe;
    logic [1:0]               sigSource;
    logic                     busy;

    qsys_st_conduit_arbiter #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ), .HOLD_CYCLES(HOLD_CYCLES)) dut (
        .clock(clock), .reset(reset), .sinkData(sinkData), .sinkValid(sinkValid),
        .sinkReady(sinkReady), .sigOut(sigOut), .sigStrobe(sigStrobe),
        .sigSource(sigSource), .busy(busy)
    );

    always #5 clock = ~clock;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model. The priority order is kept as a queue. A winner moves
    // to the back of the queue, so the requester after it gets first priority.
    int prio[$];
    int m_out, m_src, m_stb, m_hold;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        prio   = {0, 1, 2, 3};
        m_out  = 0;
        m_src  = 0;
        m_stb  = 0;
        m_hold = 0;
    endtask

    // One clock cycle: drive the inputs, check the outputs against the model, then advance the model
    task automatic step(input logic rst, input logic [NUM_REQ-1:0] v, input logic [NUM_REQ*WIDTH-1:0] d);
        int win;
        int x;
        logic [NUM_REQ-1:0] exp_rdy;
        @(negedge clock);
        reset = rst; sinkValid = v; sinkData = d;
        #1;
        win = -1;
        foreach (prio[i]) if (win < 0 && v[prio[i]]) win = prio[i];
        exp_rdy = '0;
        if (!rst && m_hold == 0 && win >= 0) exp_rdy[win] = 1'b1;
        chk("sinkReady", 32'(sinkReady), 32'(exp_rdy));
        chk("sigOut",    32'(sigOut),    32'(m_out));
        chk("sigStrobe", 32'(sigStrobe), 32'(m_stb));
        chk("sigSource", 32'(sigSource), 32'(m_src));
        chk("busy",      32'(busy),      32'(m_hold > 0));
        if (rst) model_reset();
        else if (m_hold > 0) begin
            m_hold--;
            m_stb = 0;
        end else if (win >= 0) begin
            m_out = int'(d[win*WIDTH +: WIDTH]);
            m_src = win;
            m_stb = 1;
            do begin x = prio.pop_front(); prio.push_back(x); end while (x != win);
`ifdef QSYS_ARB_HOLD_EN
            m_hold = HOLD_CYCLES;
`endif
        end else m_stb = 0;
    endtask

    function automatic logic [NUM_REQ*WIDTH-1:0] lane(input int i, input logic [7:0] b);
        logic [NUM_REQ*WIDTH-1:0] r;
        r = '0;
        r[i*WIDTH +: WIDTH] = b;
        return r;
    endfunction

    localparam logic [NUM_REQ*WIDTH-1:0] IDXDATA = 32'h33221100;

    initial begin
        model_reset();
        reset = 1'b1; sinkValid = '0; sinkData = '0;
        // Hold reset for 3 cycles with every requester valid
        repeat (3) step(1'b1, 4'b1111, IDXDATA);
        chk("rst_ready", 32'(sinkReady), 32'h0);
        // The first grant after reset goes to requester 0
        step(1'b0, 4'b1111, IDXDATA);
        chk("first_grant", 32'(sinkReady), 32'h1);
        step(1'b1, 4'b0000, '0);

`ifndef QSYS_ARB_HOLD_EN
        // Only req2 valid: two beats accepted on consecutive cycles
        step(1'b0, 4'b0100, lane(2, 8'hA5));
        step(1'b0, 4'b0100, lane(2, 8'h3C));
        chk("t2_out0", 32'(sigOut), 32'hA5);
        chk("t2_src0", 32'(sigSource), 32'd2);
        step(1'b0, 4'b0000, '0);
        chk("t2_out1", 32'(sigOut), 32'h3C);
        chk("t2_stb1", 32'(sigStrobe), 32'd1);
        step(1'b0, 4'b0000, '0);
        chk("t2_stb_off", 32'(sigStrobe), 32'd0);
        chk("t2_hold", 32'(sigOut), 32'h3C);

        // All four requesters valid: grant order 0,1,2,3,0
        step(1'b1, 4'b0000, '0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 4'b1111, IDXDATA);
            chk("t3_order", 32'(sinkReady), 32'(1 << (i % 4)));
        end
        step(1'b0, 4'b0000, '0);
        chk("t3_wrap_out", 32'(sigOut), 32'h00);

        // With lastGrant=1, req2 drops out, so req3 wins and then req1
        step(1'b1, 4'b0000, '0);
        step(1'b0, 4'b0001, '0);
        step(1'b0, 4'b0010, '0);
        step(1'b0, 4'b1010, IDXDATA);
        chk("t4_req3", 32'(sinkReady), 32'b1000);
        step(1'b0, 4'b1010, IDXDATA);
        chk("t4_req1", 32'(sinkReady), 32'b0010);
`else
        // req0 and req1 always valid: accepts are spaced HOLD_CYCLES+1 apart
        for (int i = 0; i < 3 * (HOLD_CYCLES + 1); i++) begin
            step(1'b0, 4'b0011, IDXDATA);
            chk("t5_ready", 32'(sinkReady), (i % (HOLD_CYCLES + 1) == 0) ? 32'(1 << ((i / (HOLD_CYCLES + 1)) % 2)) : 32'h0);
        end
        // Reset in the second HOLD cycle clears all state
        step(1'b1, 4'b0000, '0);
        step(1'b0, 4'b0001, lane(0, 8'h5A));
        step(1'b0, 4'b0000, '0);
        step(1'b1, 4'b0000, '0);
        step(1'b0, 4'b0001, lane(0, 8'h77));
        chk("t6_busy", 32'(busy), 32'd0);
        chk("t6_out", 32'(sigOut), 32'h0);
        chk("t6_ready", 32'(sinkReady), 32'h1);
`endif

        // Random traffic with occasional resets
        for (int n = 0; n < 3000; n++)
            step(($urandom_range(0, 99) < 2), 4'($urandom), 32'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
